// File: rtl/temp_frame_pkg.sv
// Shared constants, state encodings and checksum helper for the temperature frame transmitter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Configuration macro: TX_CHECKSUM_EN
//   defined   -> 5-byte frame, byte 4 is the 8-bit wrapping checksum
//   undefined -> 4-byte frame, no checksum logic
package temp_frame_pkg;

    localparam logic [7:0] HDR0 = 8'hA5;
    localparam logic [7:0] HDR1 = 8'h5A;

`ifdef TX_CHECKSUM_EN
    localparam int FRAME_LEN = 5;
`else
    localparam int FRAME_LEN = 4;
`endif

    // Frame-level sequencing
    typedef enum logic [1:0] {
        F_IDLE,
        F_LOAD,
        F_SEND,
        F_DONE
    } frame_state_t;

    // Bit-level sequencing; DATA states are consecutive so the serializer
    // can step through them with a simple increment.
    typedef enum logic [3:0] {
        B_IDLE  = 4'd0,
        B_START = 4'd1,
        B_DATA0 = 4'd2,
        B_DATA1 = 4'd3,
        B_DATA2 = 4'd4,
        B_DATA3 = 4'd5,
        B_DATA4 = 4'd6,
        B_DATA5 = 4'd7,
        B_DATA6 = 4'd8,
        B_DATA7 = 4'd9,
        B_STOP  = 4'd10
    } bit_state_t;

    // 8-bit wrapping sum of both header bytes and both data bytes
    function automatic logic [7:0] frame_checksum(input logic [15:0] data);
        return HDR0 + HDR1 + data[15:8] + data[7:0];
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// Single-byte 8N1 UART serializer (start, 8 data bits LSB first, stop).
// Latency: line goes low the cycle after load; byte takes 10*BPS_CNT cycles.
// Backpressure: load is honoured only while idle; the caller waits for byte_done.
//
// Ports:
//   clk, rst   rising-edge clock, asynchronous active-high reset
//   load       one-cycle request to start sending byte_in
//   byte_in    byte to transmit, captured with load
//   rs232_tx   serial line, idle high
//   byte_done  one-cycle pulse during the last cycle of the stop bit
//
// BPS_CNT must be at least 2 (byte_done is registered from a one-cycle-early decode).
module uart_tx_byte
    import temp_frame_pkg::*;
#(
    parameter int BPS_CNT = 5208
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] byte_in,
    output logic       rs232_tx,
    output logic       byte_done
);

    localparam int CNT_W = (BPS_CNT > 1) ? $clog2(BPS_CNT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BPS_CNT - 1);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(BPS_CNT - 2);

    bit_state_t       bit_state;
    logic [CNT_W-1:0] baud_cnt;
    logic [7:0]       shreg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_state <= B_IDLE;
            baud_cnt  <= '0;
            shreg     <= '0;
            rs232_tx  <= 1'b1;
            byte_done <= 1'b0;
        end else begin
            // Decoded one cycle early so the pulse lines up with the final stop-bit cycle
            byte_done <= (bit_state == B_STOP) && (baud_cnt == CNT_PRE);

            if (bit_state == B_IDLE) begin
                // Baud counter is parked at zero between bytes
                baud_cnt <= '0;
                if (load) begin
                    bit_state <= B_START;
                    shreg     <= byte_in;
                    rs232_tx  <= 1'b0;
                end
            end else if (baud_cnt == CNT_LAST) begin
                baud_cnt <= '0;
                case (bit_state)
                    B_STOP: begin
                        bit_state <= B_IDLE;
                    end
                    B_DATA7: begin
                        bit_state <= B_STOP;
                        rs232_tx  <= 1'b1;
                    end
                    default: begin
                        // START or DATA0..DATA6: present the next data bit
                        bit_state <= bit_state_t'(bit_state + 4'd1);
                        rs232_tx  <= shreg[0];
                        shreg     <= {1'b0, shreg[7:1]};
                    end
                endcase
            end else begin
                baud_cnt <= baud_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/temp_frame_tx.sv
// Temperature frame transmitter: A5 5A hi lo [checksum] as back-to-back 8N1 bytes.
// Latency: start bit from 2 cycles after acceptance; tx_done at T+1+FRAME_LEN*(10*BPS_CNT+1).
// Backpressure: none; tx_start is ignored unless idle, no queuing.
//
// Ports:
//   clk, rst   rising-edge clock, asynchronous active-high reset
//   tx_start   one-cycle send request
//   tx_data    16-bit temperature word, sampled on acceptance only
//   rs232_tx   serial line, idle high
//   tx_busy    high from the cycle after acceptance through the tx_done cycle
//   tx_done    one-cycle pulse at frame end
//
// Configuration macro: TX_CHECKSUM_EN (defined -> checksum byte appended)
module temp_frame_tx
    import temp_frame_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 9600
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tx_start,
    input  logic [15:0] tx_data,
    output logic        rs232_tx,
    output logic        tx_busy,
    output logic        tx_done
);

    localparam int BPS_CNT = CLK_FREQ / BAUD;
    localparam logic [2:0] LAST_IDX = 3'(FRAME_LEN - 1);

    frame_state_t state;
    logic [2:0]   byte_idx;
    logic [7:0]   data_hi;
    logic [7:0]   data_lo;
`ifdef TX_CHECKSUM_EN
    logic [7:0]   csum_q;
`endif

    logic       load;
    logic       byte_done;
    logic [7:0] byte_mux;

    // The serializer is idle for the whole LOAD cycle, so LOAD doubles as its load strobe
    assign load = (state == F_LOAD);

    always_comb begin
        byte_mux = HDR0;
        case (byte_idx)
            3'd0:    byte_mux = HDR0;
            3'd1:    byte_mux = HDR1;
            3'd2:    byte_mux = data_hi;
            3'd3:    byte_mux = data_lo;
`ifdef TX_CHECKSUM_EN
            3'd4:    byte_mux = csum_q;
`endif
            default: byte_mux = HDR0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= F_IDLE;
            byte_idx <= '0;
            data_hi  <= '0;
            data_lo  <= '0;
`ifdef TX_CHECKSUM_EN
            csum_q   <= '0;
`endif
            tx_busy  <= 1'b0;
            tx_done  <= 1'b0;
        end else begin
            case (state)
                F_IDLE: begin
                    if (tx_start) begin
                        data_hi  <= tx_data[15:8];
                        data_lo  <= tx_data[7:0];
`ifdef TX_CHECKSUM_EN
                        csum_q   <= frame_checksum(tx_data);
`endif
                        byte_idx <= '0;
                        tx_busy  <= 1'b1;
                        state    <= F_LOAD;
                    end
                end
                F_LOAD: begin
                    state <= F_SEND;
                end
                F_SEND: begin
                    if (byte_done) begin
                        if (byte_idx == LAST_IDX) begin
                            tx_done <= 1'b1;
                            state   <= F_DONE;
                        end else begin
                            byte_idx <= byte_idx + 3'd1;
                            state    <= F_LOAD;
                        end
                    end
                end
                F_DONE: begin
                    // tx_start here is deliberately not looked at
                    tx_done <= 1'b0;
                    tx_busy <= 1'b0;
                    state   <= F_IDLE;
                end
                default: begin
                    state <= F_IDLE;
                end
            endcase
        end
    end

    uart_tx_byte #(
        .BPS_CNT (BPS_CNT)
    ) u_byte (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .byte_in   (byte_mux),
        .rs232_tx  (rs232_tx),
        .byte_done (byte_done)
    );

endmodule
